// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the HI/LO multiply/divide controller.
// The opcode encodings, data width and zero value are defined here.
package muldiv_ctrl_pkg;

    localparam int REG_DATA_W = 32;
    localparam int CNT_W      = 5;

    typedef logic [REG_DATA_W-1:0] reg_data_t;

    localparam reg_data_t ZERO = '0;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Two's-complement negate when neg is set, pass-through otherwise.
    function automatic reg_data_t neg_if(input reg_data_t v, input logic neg);
        return neg ? ZERO - v : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, subtract
// the divisor when it fits, and report the resulting quotient bit.
module muldiv_ctrl_div_step
    import muldiv_ctrl_pkg::*;
(
    input  reg_data_t rem,
    input  logic      dividend_bit,
    input  reg_data_t divisor,
    output reg_data_t rem_next,
    output logic      q_bit
);

    logic [REG_DATA_W:0] shifted;

    assign shifted = {rem, dividend_bit};
    assign q_bit   = (shifted >= {1'b0, divisor});

    // The remainder after a successful subtract is below the divisor, so the
    // low word of the shifted value minus the divisor is exact.
    assign rem_next = q_bit ? (shifted[REG_DATA_W-1:0] - divisor)
                            : shifted[REG_DATA_W-1:0];

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller: single-cycle multiply and moves,
// 32-cycle restoring divide, one-cycle write strobe to the HI/LO register.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] op,
    input  reg_data_t  opa,
    input  reg_data_t  opb,
    input  logic       cancel,
    input  reg_data_t  hi_cur,
    input  reg_data_t  lo_cur,
    output logic       busy,
    output reg_data_t  hi_o,
    output reg_data_t  lo_o,
    output logic       wspreg
);

    state_t                 state_reg;
    logic [CNT_W-1:0]       count_reg;
    reg_data_t              rem_reg;
    reg_data_t              quo_reg;
    reg_data_t              divisor_reg;
    logic                   neg_q_reg;
    logic                   neg_r_reg;
    reg_data_t              hi_reg;
    reg_data_t              lo_reg;

    logic [2*REG_DATA_W-1:0] prod_s;
    logic [2*REG_DATA_W-1:0] prod_u;
    logic                    div_signed;
    reg_data_t               mag_a;
    reg_data_t               mag_b;
    reg_data_t               rem_next;
    reg_data_t               quo_final;
    logic                    q_bit;

    // Low 64 bits of the product of sign-extended operands is the signed product.
    assign prod_s = {{REG_DATA_W{opa[REG_DATA_W-1]}}, opa} *
                    {{REG_DATA_W{opb[REG_DATA_W-1]}}, opb};
    assign prod_u = {ZERO, opa} * {ZERO, opb};

    assign div_signed = (op == OP_DIV);
    assign mag_a      = neg_if(opa, div_signed && opa[REG_DATA_W-1]);
    assign mag_b      = neg_if(opb, div_signed && opb[REG_DATA_W-1]);

    // quo_reg doubles as the dividend shift register: its MSB feeds each step
    // while quotient bits enter at the bottom.
    assign quo_final = {quo_reg[REG_DATA_W-2:0], q_bit};

    muldiv_ctrl_div_step u_div_step (
        .rem          (rem_reg),
        .dividend_bit (quo_reg[REG_DATA_W-1]),
        .divisor      (divisor_reg),
        .rem_next     (rem_next),
        .q_bit        (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            count_reg   <= '0;
            rem_reg     <= ZERO;
            quo_reg     <= ZERO;
            divisor_reg <= ZERO;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            hi_reg      <= ZERO;
            lo_reg      <= ZERO;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start && !cancel) begin
                        case (op)
                            OP_MULT: begin
                                {hi_reg, lo_reg} <= prod_s;
                                state_reg        <= S_DONE;
                            end
                            OP_MULTU: begin
                                {hi_reg, lo_reg} <= prod_u;
                                state_reg        <= S_DONE;
                            end
                            OP_MTHI: begin
                                hi_reg    <= opa;
                                lo_reg    <= lo_cur;
                                state_reg <= S_DONE;
                            end
                            OP_MTLO: begin
                                hi_reg    <= hi_cur;
                                lo_reg    <= opa;
                                state_reg <= S_DONE;
                            end
                            OP_DIV, OP_DIVU: begin
                                // Divide-by-zero is silently dropped.
                                if (opb != ZERO) begin
                                    rem_reg     <= ZERO;
                                    quo_reg     <= mag_a;
                                    divisor_reg <= mag_b;
                                    neg_q_reg   <= div_signed &&
                                                   (opa[REG_DATA_W-1] ^ opb[REG_DATA_W-1]);
                                    neg_r_reg   <= div_signed && opa[REG_DATA_W-1];
                                    count_reg   <= '0;
                                    state_reg   <= S_DIV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_DIV: begin
                    if (cancel) begin
                        count_reg <= '0;
                        state_reg <= S_IDLE;
                    end else begin
                        rem_reg   <= rem_next;
                        quo_reg   <= quo_final;
                        count_reg <= count_reg + 1'b1;
                        if (count_reg == '1) begin
                            lo_reg    <= neg_if(quo_final, neg_q_reg);
                            hi_reg    <= neg_if(rem_next, neg_r_reg);
                            state_reg <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_reg != S_IDLE);
    assign wspreg = (state_reg == S_DONE) && !cancel;
    assign hi_o   = hi_reg;
    assign lo_o   = lo_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized ops checked against an arithmetic reference model.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       start  = 1'b0;
    logic       cancel = 1'b0;
    logic [2:0] op     = 3'd0;
    reg_data_t  opa    = '0;
    reg_data_t  opb    = '0;
    reg_data_t  hi_cur;
    reg_data_t  lo_cur;
    reg_data_t  hi_o;
    reg_data_t  lo_o;
    logic       busy;
    logic       wspreg;

    reg_data_t  sr_hi;
    reg_data_t  sr_lo;
    reg_data_t  m_hi = '0;
    reg_data_t  m_lo = '0;
    int         errors = 0;
    int         checks = 0;

    typedef struct {
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] eh;
        logic [31:0] el;
        int          mid;
    } vec_t;

    vec_t vecs[13];

    muldiv_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .opa    (opa),
        .opb    (opb),
        .cancel (cancel),
        .hi_cur (hi_cur),
        .lo_cur (lo_cur),
        .busy   (busy),
        .hi_o   (hi_o),
        .lo_o   (lo_o),
        .wspreg (wspreg)
    );

    always #5 clk = ~clk;

    // Behavioural HI/LO special register fed by the write strobe.
    always @(posedge clk) begin
        if (rst) begin
            sr_hi <= '0;
            sr_lo <= '0;
        end else if (wspreg) begin
            sr_hi <= hi_o;
            sr_lo <= lo_o;
        end
    end
    assign hi_cur = sr_hi;
    assign lo_cur = sr_lo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        tick();
        start = 1'b0;
    endtask

    task automatic watch(input int n, output logic saw_busy, output logic saw_ws);
        saw_busy = 1'b0;
        saw_ws   = 1'b0;
        for (int i = 0; i < n; i++) begin
            saw_busy |= busy;
            saw_ws   |= wspreg;
            tick();
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definitions.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output int lat, output logic [31:0] h, output logic [31:0] l);
        longint signed   sa, sb, q, r;
        longint unsigned ua, ub, p;
        h   = m_hi;
        l   = m_lo;
        lat = 0;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'(a);
        ub  = longint'(b);
        case (o)
            OP_MULT:  begin q = sa * sb; {h, l} = q; lat = 1; end
            OP_MULTU: begin p = ua * ub; {h, l} = p; lat = 1; end
            OP_DIV: if (b != 0) begin
                q = sa / sb; r = sa % sb;
                l = q[31:0]; h = r[31:0]; lat = 33;
            end
            OP_DIVU: if (b != 0) begin
                p = ua / ub; l = p[31:0]; p = ua % ub; h = p[31:0]; lat = 33;
            end
            OP_MTHI:  begin h = a; l = sr_lo; lat = 1; end
            OP_MTLO:  begin h = sr_hi; l = a; lat = 1; end
            default: ;
        endcase
    endfunction

    task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] eh,
                         input logic [31:0] el, input int mid_start);
        int   lat;
        logic gap, sb, sw;
        issue(o, a, b);
        if (exp_lat == 0) begin
            watch(35, sb, sw);
            lat = 0;
            check({name, ".busy_seen"}, 32'(sb), 32'd0);
            check({name, ".ws_seen"}, 32'(sw), 32'd0);
            check({name, ".hi"}, hi_o, eh);
            check({name, ".lo"}, lo_o, el);
        end else begin
            lat = 1;
            gap = 1'b0;
            while (!wspreg && lat < 40) begin
                if (!busy) gap = 1'b1;
                if (lat == mid_start) begin
                    start = 1'b1; op = OP_MULTU; opa = 32'd3; opb = 32'd4;
                end
                tick();
                start = 1'b0;
                lat++;
            end
            check({name, ".latency"}, 32'(lat), 32'(exp_lat));
            check({name, ".busy_gap"}, 32'(gap), 32'd0);
            check({name, ".busy_done"}, 32'(busy), 32'd1);
            check({name, ".hi"}, hi_o, eh);
            check({name, ".lo"}, lo_o, el);
            m_hi = eh;
            m_lo = el;
            tick();
            check({name, ".busy_after"}, 32'(busy), 32'd0);
            check({name, ".ws_after"}, 32'(wspreg), 32'd0);
        end
        $display("%s op=%0d a=%h b=%h lat=%0d hi=%h lo=%h", name, o, a, b, lat, hi_o, lo_o);
    endtask

    initial begin
        int          lat;
        logic [31:0] h, l, ra, rb;
        logic [2:0]  ro;
        logic        sb, sw;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1,  32'hFFFFFFFE, 32'h00000001, 0};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 1,  32'hFFFFFFFF, 32'hFFFFFFF1, 0};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{OP_DIVU,  32'd100,      32'd7,        33, 32'h00000002, 32'h0000000E, 0};
        vecs[4]  = '{OP_MTHI,  32'h0000AAAA, 32'h0,        1,  32'h0000AAAA, 32'h0000000E, 0};
        vecs[5]  = '{OP_MTLO,  32'h00005555, 32'h0,        1,  32'h0000AAAA, 32'h00005555, 0};
        vecs[6]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000, 0};
        vecs[7]  = '{OP_DIV,   32'd5,        32'd0,        0,  32'h00000000, 32'h80000000, 0};
        vecs[8]  = '{3'd7,     32'd1,        32'd1,        0,  32'h00000000, 32'h80000000, 0};
        vecs[9]  = '{OP_MULT,  32'd7,        32'hFFFFFFFE, 1,  32'hFFFFFFFF, 32'hFFFFFFF2, 0};
        vecs[10] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 33, 32'h00000001, 32'hFFFFFFFD, 0};
        vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        33, 32'h00000000, 32'hFFFFFFFF, 0};
        vecs[12] = '{3'd6,     32'd9,        32'd9,        0,  32'h00000000, 32'hFFFFFFFF, 0};

        // Reset, with a start held high to confirm reset wins.
        start = 1'b1; op = OP_MULTU; opa = 32'd3; opb = 32'd4;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.ws", 32'(wspreg), 32'd0);
        check("reset.hi", hi_o, 32'd0);
        check("reset.lo", lo_o, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].o, vecs[i].a, vecs[i].b,
                  vecs[i].lat, vecs[i].eh, vecs[i].el, vecs[i].mid);

        // Cancel at division cycle 10, then an MTLO.
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (9) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_div.busy", 32'(busy), 32'd0);
        watch(35, sb, sw);
        check("cancel_div.ws_seen", 32'(sw), 32'd0);
        check("cancel_div.busy_seen", 32'(sb), 32'd0);
        $display("cancel_div busy=%0d ws_seen=%0d", busy, sw);
        model(OP_MTLO, 32'h1234, 32'h0, lat, h, l);
        check("mtlo_after_cancel.model_lo", l, 32'h00001234);
        do_op("mtlo_after_cancel", OP_MTLO, 32'h1234, 32'h0, lat, h, l, 0);

        // Cancel while in DONE: strobe suppressed, result not written.
        issue(OP_MULT, 32'd6, 32'd7);
        cancel = 1'b1;
        #1;
        check("cancel_done.ws", 32'(wspreg), 32'd0);
        check("cancel_done.busy", 32'(busy), 32'd1);
        tick();
        cancel = 1'b0;
        check("cancel_done.busy_after", 32'(busy), 32'd0);
        check("cancel_done.lo", lo_o, 32'd42);
        m_hi = 32'd0;
        m_lo = 32'd42;
        $display("cancel_done hi=%h lo=%h", hi_o, lo_o);
        do_op("mthi_after_cancel", OP_MTHI, 32'hBEEF, 32'h0, 1, 32'h0000BEEF, 32'h00001234, 0);

        // Start together with cancel is ignored.
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = OP_MULTU; opa = 32'd5; opb = 32'd5;
        tick();
        start = 1'b0; cancel = 1'b0;
        check("start_cancel.busy", 32'(busy), 32'd0);
        check("start_cancel.lo", lo_o, 32'h00001234);
        $display("start_cancel busy=%0d lo=%h", busy, lo_o);

        // Reset in the middle of a division.
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (5) tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("rst_mid.busy", 32'(busy), 32'd0);
        check("rst_mid.ws", 32'(wspreg), 32'd0);
        check("rst_mid.hi", hi_o, 32'd0);
        check("rst_mid.lo", lo_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        watch(35, sb, sw);
        check("rst_mid.ws_seen", 32'(sw), 32'd0);
        $display("rst_mid busy_seen=%0d ws_seen=%0d", sb, sw);

        // Randomized ops against the reference model.
        for (int n = 0; n < 150; n++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            model(ro, ra, rb, lat, h, l);
            do_op($sformatf("rnd%0d", n), ro, ra, rb, lat, h, l, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
